elevator_request_queue: RTL and testbench



---
 rtl/elevator_pkg.sv | 7 +
 rtl/elevator_button_sync.sv | 34 +++
 rtl/elevator_request_queue.sv | 72 +++++++
 tb/tb_elevator_request_queue.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// Shared types and sizes for the elevator request queue.
// Floor indices are 3 bits wide, so at most 8 floors are served.
package elevator_pkg;
   localparam int FLOOR_IDX_W = 3;
   localparam int MAX_FLOORS  = 8;
   typedef logic [FLOOR_IDX_W-1:0] floor_idx_t;
endpackage

// File: rtl/elevator_button_sync.sv
// Car panel button conditioner: 2-flop synchronizer per bit followed
// by a rising-edge detector.
// Ports: clk, reset (sync, active-high), buttons[7:0] raw async inputs,
//        press_pulse[7:0] one-cycle pulse per detected press.
module elevator_button_sync
   import elevator_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic [MAX_FLOORS-1:0] buttons,
   output logic [MAX_FLOORS-1:0] press_pulse
);

   logic [MAX_FLOORS-1:0] meta;
   logic [MAX_FLOORS-1:0] sync;
   logic [MAX_FLOORS-1:0] prev;

   always_ff @(posedge clk) begin
      if (reset) begin
         meta <= '0;
         sync <= '0;
         prev <= '0;
      end else begin
         meta <= buttons;
         sync <= meta;
         prev <= sync;
      end
   end

   // prev clears on reset, so a button held through reset
   // release still shows one rise afterwards.
   assign press_pulse = sync & ~prev;

endmodule

// File: rtl/elevator_request_queue.sv
// Pending floor request register for one car, set/cleared by the
// controller bus and set by the car push-button panel.
// Ports: clk, reset (sync, active-high); r_nwr (0 = write),
//        deassert_floor (1 = clear), requested_floor[2:0];
//        buttons[7:0] raw panel; queue_status[FLOOR_COUNT-1:0];
//        button_panel_light[7:0] lamps mirroring the queue.
module elevator_request_queue
   import elevator_pkg::*;
#(
   parameter int FLOOR_COUNT = 7
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   r_nwr,
   input  logic                   deassert_floor,
   input  logic [FLOOR_IDX_W-1:0] requested_floor,
   input  logic [MAX_FLOORS-1:0]  buttons,
   output logic [FLOOR_COUNT-1:0] queue_status,
   output logic [MAX_FLOORS-1:0]  button_panel_light
);

   localparam logic [FLOOR_IDX_W:0] FC =
      (FLOOR_IDX_W+1)'(FLOOR_COUNT);

   localparam logic [MAX_FLOORS-1:0] FLOOR_MASK =
      MAX_FLOORS'((9'd1 << FLOOR_COUNT) - 9'd1);

   logic [MAX_FLOORS-1:0] press_pulse;
   logic [MAX_FLOORS-1:0] onehot;
   logic [MAX_FLOORS-1:0] set_mask;
   logic [MAX_FLOORS-1:0] clr_mask;
   logic [MAX_FLOORS-1:0] cur;
   logic [MAX_FLOORS-1:0] nxt;
   logic                  wr_ok;

   elevator_button_sync u_sync (
      .clk         (clk),
      .reset       (reset),
      .buttons     (buttons),
      .press_pulse (press_pulse)
   );

   // Out-of-range floors never reach the masks.
   assign wr_ok  = !r_nwr && ({1'b0, requested_floor} < FC);
   assign onehot = MAX_FLOORS'(1) << requested_floor;

   always_comb begin
      set_mask = '0;
      clr_mask = '0;
      if (wr_ok) begin
         if (deassert_floor) clr_mask = onehot;
         else                set_mask = onehot;
      end
   end

   assign cur = MAX_FLOORS'(queue_status);

   // Clear is applied last so a bus clear beats a same-cycle press.
   assign nxt = ((cur | set_mask | press_pulse) & ~clr_mask)
                & FLOOR_MASK;

   always_ff @(posedge clk) begin
      if (reset) begin
         queue_status       <= '0;
         button_panel_light <= '0;
      end else begin
         queue_status       <= nxt[FLOOR_COUNT-1:0];
         button_panel_light <= nxt;
      end
   end

endmodule

// File: tb/tb_elevator_request_queue.sv
// Directed self-checking bench for elevator_request_queue.
// Each scenario task drives vectors and compares against hand values.
module tb_elevator_request_queue;

   logic       clk = 1'b0;
   logic       reset;
   logic       r_nwr;
   logic       deassert_floor;
   logic [2:0] requested_floor;
   logic [7:0] buttons;
   logic [6:0] queue_status;
   logic [7:0] button_panel_light;

   int pass_cnt = 0;
   int total    = 0;

   elevator_request_queue #(.FLOOR_COUNT(7)) dut (
      .clk                (clk),
      .reset              (reset),
      .r_nwr              (r_nwr),
      .deassert_floor     (deassert_floor),
      .requested_floor    (requested_floor),
      .buttons            (buttons),
      .queue_status       (queue_status),
      .button_panel_light (button_panel_light)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      r_nwr           = 1'b1;
      deassert_floor  = 1'b0;
      requested_floor = 3'd0;
   endtask

   task automatic wr(input logic clr, input logic [2:0] f);
      r_nwr           = 1'b0;
      deassert_floor  = clr;
      requested_floor = f;
      tick();
      idle();
   endtask

   task automatic test_reset();
      reset   = 1'b1;
      buttons = 8'h00;
      idle();
      tick();
      reset = 1'b0;
      total++;
      if (queue_status !== 7'b0)
         $display("FAIL reset_q: got %b want %b", queue_status, 7'b0);
      else pass_cnt++;
      total++;
      if (button_panel_light !== 8'h00)
         $display("FAIL reset_l: got %h want %h", button_panel_light, 8'h00);
      else pass_cnt++;
      tick();
   endtask

   task automatic test_bus_set_clear();
      wr(1'b0, 3'd2);
      total++;
      if (queue_status !== 7'b0000100)
         $display("FAIL set2: got %b want %b", queue_status, 7'b0000100);
      else pass_cnt++;
      wr(1'b0, 3'd3);
      total++;
      if (queue_status !== 7'b0001100)
         $display("FAIL set3: got %b want %b", queue_status, 7'b0001100);
      else pass_cnt++;
      total++;
      if (button_panel_light !== 8'h0C)
         $display("FAIL set3_l: got %h want %h", button_panel_light, 8'h0C);
      else pass_cnt++;
      wr(1'b0, 3'd3);
      total++;
      if (queue_status !== 7'b0001100)
         $display("FAIL idem_set: got %b want %b", queue_status, 7'b0001100);
      else pass_cnt++;
      wr(1'b1, 3'd2);
      total++;
      if (queue_status !== 7'b0001000)
         $display("FAIL clr2: got %b want %b", queue_status, 7'b0001000);
      else pass_cnt++;
      total++;
      if (button_panel_light !== 8'h08)
         $display("FAIL clr2_l: got %h want %h", button_panel_light, 8'h08);
      else pass_cnt++;
      wr(1'b1, 3'd2);
      total++;
      if (queue_status !== 7'b0001000)
         $display("FAIL idem_clr: got %b want %b", queue_status, 7'b0001000);
      else pass_cnt++;
   endtask

   task automatic test_out_of_range();
      wr(1'b0, 3'd7);
      total++;
      if (queue_status !== 7'b0001000)
         $display("FAIL oor_set: got %b want %b", queue_status, 7'b0001000);
      else pass_cnt++;
      total++;
      if (button_panel_light !== 8'h08)
         $display("FAIL oor_l: got %h want %h", button_panel_light, 8'h08);
      else pass_cnt++;
      r_nwr           = 1'b1;
      deassert_floor  = 1'b1;
      requested_floor = 3'd3;
      tick();
      idle();
      total++;
      if (queue_status !== 7'b0001000)
         $display("FAIL idle_rd: got %b want %b", queue_status, 7'b0001000);
      else pass_cnt++;
   endtask

   task automatic test_button_hold();
      buttons = 8'h20;
      tick();
      tick();
      total++;
      if (queue_status !== 7'b0001000)
         $display("FAIL btn_early: got %b want %b", queue_status, 7'b0001000);
      else pass_cnt++;
      tick();
      total++;
      if (queue_status !== 7'b0101000)
         $display("FAIL btn_set: got %b want %b", queue_status, 7'b0101000);
      else pass_cnt++;
      total++;
      if (button_panel_light !== 8'h28)
         $display("FAIL btn_l: got %h want %h", button_panel_light, 8'h28);
      else pass_cnt++;
      tick();
      tick();
      wr(1'b1, 3'd5);
      for (int i = 0; i < 4; i++) tick();
      total++;
      if (queue_status !== 7'b0001000)
         $display("FAIL btn_retrig: got %b want %b", queue_status, 7'b0001000);
      else pass_cnt++;
      buttons = 8'h80;
      for (int i = 0; i < 5; i++) tick();
      total++;
      if (button_panel_light !== 8'h08)
         $display("FAIL btn7_l: got %h want %h", button_panel_light, 8'h08);
      else pass_cnt++;
      buttons = 8'h00;
      for (int i = 0; i < 4; i++) tick();
   endtask

   task automatic test_simultaneous();
      wr(1'b0, 3'd4);
      buttons = 8'h10;
      tick();
      tick();
      total++;
      if (queue_status !== 7'b0011000)
         $display("FAIL sim_pre: got %b want %b", queue_status, 7'b0011000);
      else pass_cnt++;
      wr(1'b1, 3'd4);
      total++;
      if (queue_status !== 7'b0001000)
         $display("FAIL clr_beats: got %b want %b", queue_status, 7'b0001000);
      else pass_cnt++;
      buttons = 8'h02;
      tick();
      tick();
      wr(1'b0, 3'd1);
      total++;
      if (queue_status !== 7'b0001010)
         $display("FAIL set_merge: got %b want %b", queue_status, 7'b0001010);
      else pass_cnt++;
      buttons = 8'h01;
      tick();
      tick();
      wr(1'b1, 3'd3);
      total++;
      if (queue_status !== 7'b0000011)
         $display("FAIL indep: got %b want %b", queue_status, 7'b0000011);
      else pass_cnt++;
      buttons = 8'h00;
      for (int i = 0; i < 4; i++) tick();
      total++;
      if (queue_status !== 7'b0000011)
         $display("FAIL sim_post: got %b want %b", queue_status, 7'b0000011);
      else pass_cnt++;
   endtask

   task automatic test_reset_override();
      for (int f = 0; f < 7; f++) wr(1'b0, 3'(f));
      total++;
      if (queue_status !== 7'h7F)
         $display("FAIL full: got %h want %h", queue_status, 7'h7F);
      else pass_cnt++;
      total++;
      if (button_panel_light !== 8'h7F)
         $display("FAIL full_l: got %h want %h", button_panel_light, 8'h7F);
      else pass_cnt++;
      reset           = 1'b1;
      buttons         = 8'h40;
      r_nwr           = 1'b0;
      deassert_floor  = 1'b0;
      requested_floor = 3'd2;
      tick();
      total++;
      if (queue_status !== 7'h00)
         $display("FAIL rst_ovr: got %h want %h", queue_status, 7'h00);
      else pass_cnt++;
      total++;
      if (button_panel_light !== 8'h00)
         $display("FAIL rst_ovr_l: got %h want %h", button_panel_light, 8'h00);
      else pass_cnt++;
      idle();
      tick();
      reset = 1'b0;
      tick();
      tick();
      total++;
      if (queue_status !== 7'h00)
         $display("FAIL held_early: got %h want %h", queue_status, 7'h00);
      else pass_cnt++;
      tick();
      total++;
      if (queue_status !== 7'b1000000)
         $display("FAIL held_rel: got %b want %b", queue_status, 7'b1000000);
      else pass_cnt++;
      buttons = 8'h00;
      tick();
   endtask

   initial begin
      reset           = 1'b1;
      buttons         = 8'h00;
      r_nwr           = 1'b1;
      deassert_floor  = 1'b0;
      requested_floor = 3'd0;
      test_reset();
      test_bus_set_clear();
      test_out_of_range();
      test_button_hold();
      test_simultaneous();
      test_reset_override();
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
